// File: rtl/counter_pkg.sv
// Shared types for the mode counter: terminal-behaviour modes and run/done state.
package counter_pkg;

   typedef enum logic [1:0] {
      CM_WRAP    = 2'd0,
      CM_SAT     = 2'd1,
      CM_ONESHOT = 2'd2,
      CM_RSVD    = 2'd3
   } cnt_mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: one tick every prescale+1 cycles in which run is high.
module cnt_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             clr,
   input  logic             run,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   assign tick = run && (cnt_q == prescale);

   // Dropping run freezes the count in place; only clr or a tick resets it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mode_counter.sv
// Up/down timer/event counter with programmable terminal value, prescaler and
// wrap / saturate / one-shot terminal behaviour; tc is a one-cycle terminal pulse.
module mode_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic [PRE_W-1:0] prescale,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   cnt_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             tick;
   logic             terminal;
   cnt_mode_e        mode_e;

   assign mode_e = cnt_mode_e'(mode);

   cnt_prescaler #(
      .PRE_W(PRE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst_     (rst_),
      .clr      (load),
      .run      (enable && (state_q == ST_RUN)),
      .prescale (prescale),
      .tick     (tick)
   );

   // Up-count uses >= so a value loaded above limit terminates on the first tick.
   assign terminal = up_dn ? (count_q >= limit) : (count_q == '0);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d  = data;
         reload_d = data;
         state_d  = ST_RUN;
      end else if (tick) begin
         if (!terminal) begin
            count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end else begin
            tc_d = 1'b1;
            unique case (mode_e)
               CM_SAT: begin
                  count_d = count_q;
               end
               CM_ONESHOT: begin
                  count_d = reload_q;
                  state_d = ST_DONE;
               end
               default: begin
                  count_d = up_dn ? '0 : limit;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= ST_RUN;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign done  = (state_q == ST_DONE);

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised successor of the team's simple loadable up-counter.
- Adds up/down direction, a programmable terminal value, and a clock-enable prescaler.
- Adds three terminal behaviours: wrap, saturate, and one-shot with auto-reload.
- Used as a general timer/event counter in lab designs; produces a one-cycle terminal-count pulse for downstream logic.

Parameters:
- WIDTH, 8, bit width of count, data and limit.
- PRE_W, 4, bit width of the prescaler divide value.

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- enable  input  1  counting enabled when high.
- load  input  1  synchronous load of data; highest priority after reset.
- data  input  WIDTH  load value; also captured as the one-shot reload value.
- up_dn  input  1  1 = count up, 0 = count down; sampled on every tick.
- mode  input  2  cnt_mode_e: 0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (behaves as WRAP).
- limit  input  WIDTH  terminal value for up-counting and wrap target for down-counting.
- prescale  input  PRE_W  a tick occurs every prescale+1 enabled cycles.
- count  output  WIDTH  current count.
- tc  output  1  registered one-cycle pulse on the tick that hits a terminal.
- done  output  1  high while the one-shot has expired (state DONE).

Behaviour:
- Reset (rst_ low, asynchronous): count=0, tc=0, done=0, prescaler counter=0, reload register=0, state=RUN.
- Priority per clock edge: load > tick > hold.
- Load:
  - count<=data, reload<=data, prescaler counter<=0, state<=RUN, tc<=0.
  - load is honoured regardless of enable.
- Prescaler:
  - While enable=1 and state=RUN, the prescaler counter increments.
  - tick is asserted when prescaler counter==prescale; the counter then clears.
  - prescale=0 gives a tick on every enabled cycle.
  - enable=0 freezes the prescaler counter (no clear).
- Terminal condition on a tick:
  - Up: count>=limit (so a value loaded above limit is terminal at once).
  - Down: count==0.
- Non-terminal tick: count<=count+1 (up) or count-1 (down), modulo 2^WIDTH; tc<=0.
- Terminal tick actions, with tc<=1 for one cycle:
  - WRAP: up -> count<=0; down -> count<=limit.
  - SAT: count holds. tc pulses on every terminal tick while held (i.e. each prescaled tick).
  - ONESHOT: count<=reload, state<=DONE, done<=1.
- State DONE:
  - No ticks are generated and the prescaler is frozen; count holds at reload.
  - Exit only via load or reset. Changing mode does not exit DONE.
- tc is 0 in every cycle without a terminal tick, including cycles after load.
- limit=0 with up-counting: every tick is terminal.
- Mode, up_dn or limit changed mid-count take effect on the next tick; no other side effects.
- Reset asserted mid-operation overrides everything immediately.
- Arithmetic is unsigned throughout; no overflow flag.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e {CM_WRAP, CM_SAT, CM_ONESHOT, CM_RSVD}
  - typedef enum logic {ST_RUN, ST_DONE} cnt_state_e
- Sub-module cnt_prescaler (parameter PRE_W):
  - Inputs: clk, rst_, clr, run, prescale.
  - Output: tick.
  - Instantiated once.

Test Plan:
- Reset then WRAP, up, limit=5, prescale=0, enable=1 -> count 0,1,2,3,4,5,0; tc high only on the edge 5->0; done=0.
- WRAP, down, load data=2, limit=9 -> count 2,1,0,9,8; tc pulses once at 0->9.
- SAT, up, limit=3, prescale=1 -> count advances every 2nd cycle to 3 and holds; tc pulses every 2nd cycle while at 3.
- ONESHOT, down, load data=4, enable=1, prescale=0 -> count 4,3,2,1,0 then 4 with tc=1 and done=1. Count stays 4 for 10 cycles; a further load data=7 clears done and counting resumes from 7.
- load and enable asserted in the same cycle with count=10, data=20 -> count=20, no increment that cycle. enable=0 for 3 cycles -> count holds 20, tc=0.
- rst_ pulsed low mid-count at count=6 (not clock-aligned) -> count=0, tc=0 and done=0 immediately; up-counting from 0 resumes after rst_ deasserts.
